wrap_monitor: RTL
=================

WRAP_MONITOR -- requirements
Module: wrap_monitor

Interface
REQ-001 Parameter WIDTH, default 3: width of the counter value consumed.
REQ-002 Parameter WRAPS, default 4, range 1..255: terminal-count events required before finish.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle request to begin a monitoring run.
REQ-006 cnt_in  input  WIDTH  current value of the upstream counter.
REQ-007 done_in  input  1  upstream terminal-count flag; high when cnt_in is all ones.
REQ-008 fin_ack  input  1  acknowledge from the finish consumer.
REQ-009 run  output  1  enable to the upstream counter; high only in RUN.
REQ-010 wrap_cnt  output  8  number of done_in rising edges seen in the current run.
REQ-011 step_err  output  1  sticky error flag.
REQ-012 fin_req  output  1  finish request; held until acknowledged.
REQ-013 state  output  2  FSM state: IDLE=0, RUN=1, FINISH=2; encoding 3 unused.

Function
REQ-014 FSM IDLE: run=0, fin_req=0; start=1 -> RUN next cycle.
REQ-015 On IDLE->RUN: clear wrap_cnt and step_err; load prev_cnt=cnt_in; load prev_done=done_in.
REQ-016 RUN: run=1; each cycle, prev_cnt<=cnt_in and prev_done<=done_in.
REQ-017 RUN step check: cnt_in must equal prev_cnt or (prev_cnt+1) mod 2^WIDTH; otherwise set step_err.
REQ-018 RUN flag check: done_in must equal (cnt_in == all ones); otherwise set step_err.
REQ-019 step_err stays sticky until the next IDLE->RUN transition or rst.
REQ-020 RUN: done_in=1 with prev_done=0 increments wrap_cnt by 1. A held done_in counts once.
REQ-021 wrap_cnt saturates at 255; it never wraps.
REQ-022 RUN -> FINISH on the cycle in which the incremented wrap_cnt equals WRAPS.
REQ-023 run is deasserted in that same next cycle, when state=FINISH.
REQ-024 FINISH: run=0, fin_req=1, wrap_cnt and step_err frozen.
REQ-025 FINISH: fin_ack=1 -> IDLE next cycle; fin_req drops with the state change.
REQ-026 FINISH -> IDLE clears fin_req only; wrap_cnt and step_err remain readable in IDLE.
REQ-027 start is ignored in RUN and in FINISH, including start and fin_ack in the same FINISH cycle. That case goes to IDLE only.
REQ-028 fin_ack is ignored outside FINISH.
REQ-029 If state ever holds encoding 3, the FSM returns to IDLE on the next cycle with all outputs 0.
REQ-030 No combinational path from any input to any output; all outputs are registered or decoded from state.

Reset
REQ-031 rst=1 at posedge clk sets state=IDLE, run=0, wrap_cnt=0, step_err=0, fin_req=0, prev_cnt=0, prev_done=0.
REQ-032 rst overrides start, fin_ack and any state, including reset mid-RUN and mid-FINISH.
REQ-033 The first posedge with rst=0 after reset evaluates normally; start on that edge enters RUN.

Verification
REQ-034 Reset then start; counter model 0..7 increments while run=1, WRAPS=4.
- Required response: wrap_cnt reaches 4, state=FINISH one cycle later, run=0, step_err=0.
REQ-035 In FINISH, hold fin_ack=0 for 5 cycles, then pulse it for 1 cycle.
- Required response: fin_req=1 throughout, then IDLE next cycle; wrap_cnt still reads 4.
REQ-036 During RUN, force cnt_in to jump 2->5.
- Required response: step_err=1 next cycle and stays 1 through FINISH; the next start clears it.
REQ-037 During RUN, drive done_in=1 with cnt_in=3.
- Required response: step_err=1, and wrap_cnt increments once for that rising edge.
REQ-038 Hold done_in=1 and cnt_in=7 for 3 cycles (counter stalled).
- Required response: wrap_cnt increments once, and step_err=0.
REQ-039 Assert rst mid-RUN with wrap_cnt=2, then start in the first post-reset cycle.
- Required response: all outputs 0 after reset, then RUN with wrap_cnt=0.

Source files
------------

// File: rtl/wrap_monitor.sv
// wrap_monitor: watches an upstream free-running counter during a run,
// counts terminal-count events, flags illegal steps or inconsistent
// terminal flags, and raises a held finish request after WRAPS events.
module wrap_monitor #(
  parameter int WIDTH = 3,
  parameter int WRAPS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             done_in,
  input  logic             fin_ack,
  output logic             run,
  output logic [7:0]       wrap_cnt,
  output logic             step_err,
  output logic             fin_req,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2,
    S_BAD    = 2'd3
  } state_t;

  localparam logic [7:0]       WRAPS_C  = 8'(WRAPS);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  state_t           state_q, state_d;
  logic [7:0]       wrap_q, wrap_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] prev_cnt_q, prev_cnt_d;
  logic             prev_done_q, prev_done_d;

  logic [WIDTH-1:0] cnt_inc;
  logic             step_ok;
  logic             flag_ok;
  logic             done_rise;
  logic [7:0]       wrap_inc;

  // Saturating increment: the event count sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Legal upstream behaviour: hold or advance by one modulo 2^WIDTH, and the
  // terminal flag must agree with the all-ones value in the same cycle.
  assign cnt_inc   = prev_cnt_q + WIDTH'(1);
  assign step_ok   = (cnt_in == prev_cnt_q) || (cnt_in == cnt_inc);
  assign flag_ok   = (done_in == (cnt_in == ALL_ONES));
  assign done_rise = done_in & ~prev_done_q;
  assign wrap_inc  = sat_inc(wrap_q);

  // Next-state and datapath updates; everything holds unless a rule fires.
  always_comb begin
    state_d     = state_q;
    wrap_d      = wrap_q;
    err_d       = err_q;
    prev_cnt_d  = prev_cnt_q;
    prev_done_d = prev_done_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_RUN;
          wrap_d      = 8'd0;
          err_d       = 1'b0;
          prev_cnt_d  = cnt_in;
          prev_done_d = done_in;
        end
      end
      S_RUN: begin
        prev_cnt_d  = cnt_in;
        prev_done_d = done_in;
        if (!step_ok || !flag_ok) begin
          err_d = 1'b1;
        end
        if (done_rise) begin
          wrap_d = wrap_inc;
          if (wrap_inc == WRAPS_C) begin
            state_d = S_FINISH;
          end
        end
      end
      S_FINISH: begin
        // start in the same cycle as fin_ack is deliberately ignored
        if (fin_ack) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        wrap_d      = 8'd0;
        err_d       = 1'b0;
        prev_cnt_d  = '0;
        prev_done_d = 1'b0;
      end
    endcase
  end

  // State register with synchronous reset of every field.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wrap_q      <= 8'd0;
      err_q       <= 1'b0;
      prev_cnt_q  <= '0;
      prev_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wrap_q      <= wrap_d;
      err_q       <= err_d;
      prev_cnt_q  <= prev_cnt_d;
      prev_done_q <= prev_done_d;
    end
  end

  // Outputs are registers or pure state decodes, so no input reaches them
  // combinationally.
  assign run      = (state_q == S_RUN);
  assign fin_req  = (state_q == S_FINISH);
  assign state    = state_q;
  assign wrap_cnt = wrap_q;
  assign step_err = err_q;

endmodule
